// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined floating-point adder/subtractor (align, add, normalise/round) with RNE and flags
module fp_add_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sub,
  input  logic [EXP_W+MAN_W:0]   in_opA,
  input  logic [EXP_W+MAN_W:0]   in_opB,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_sum,
  output logic [TAG_W-1:0]       out_tag,
  output logic [3:0]             out_flags
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int SW = MAN_W + 4;
  localparam int N = MAN_W + 5;
  localparam int LW = $clog2(N + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
  logic v1_q, v2_q, v3_q, ld1, ld2, ld3;
  assign ld3 = !v3_q | out_ready;
  assign ld2 = !v2_q | ld3;
  assign ld1 = !v1_q | ld2;
  assign in_ready = ld1;
  assign out_valid = v3_q;
  logic sa, sb, za, zb, ia, ib, na, nb, swap;
  logic [EXP_W-1:0] ea, eb, xa, xb, d;
  logic [MAN_W-1:0] fa, fb;
  logic [MAN_W:0] ma, mb;
  logic [31:0] dc;
  logic [2*SW-1:0] sh;
  assign sa = in_opA[W-1];
  assign sb = in_opB[W-1] ^ in_sub;
  assign {ea, fa} = in_opA[W-2:0];
  assign {eb, fb} = in_opB[W-2:0];
  assign xa = (ea == '0) ? EXP_W'(1) : ea;
  assign xb = (eb == '0) ? EXP_W'(1) : eb;
  assign ma = {ea != '0, fa};
  assign mb = {eb != '0, fb};
  assign na = (ea == EMAX) && (fa != '0);
  assign nb = (eb == EMAX) && (fb != '0);
  assign ia = (ea == EMAX) && (fa == '0);
  assign ib = (eb == EMAX) && (fb == '0);
  assign za = (ea == '0) && (fa == '0);
  assign zb = (eb == '0) && (fb == '0);
  assign swap = in_opB[W-2:0] > in_opA[W-2:0];
  assign d = swap ? xb - xa : xa - xb;
  assign dc = (32'(d) > 32'(SW)) ? 32'(SW) : 32'(d);
  assign sh = {swap ? ma : mb, 3'b000, {SW{1'b0}}} >> dc;
  logic spec_d;
  logic [W-1:0] sv_d;
  logic [3:0] sf_d;
  // special operands bypass the datapath; NaN first, then infinities, then zeros
  always_comb begin
    spec_d = 1'b1;
    sv_d = QNAN;
    sf_d = 4'b0000;
    if (na | nb) sf_d = {(na & !fa[MAN_W-1]) | (nb & !fb[MAN_W-1]), 3'b000};
    else if (ia & ib & (sa != sb)) sf_d = 4'b1000;
    else if (ia) sv_d = {sa, EMAX, {MAN_W{1'b0}}};
    else if (ib) sv_d = {sb, EMAX, {MAN_W{1'b0}}};
    else if (za & zb) sv_d = {sa & sb, {(W-1){1'b0}}};
    else if (zb) sv_d = in_opA;
    else if (za) sv_d = {sb, in_opB[W-2:0]};
    else spec_d = 1'b0;
  end
  logic s1_sub_q, s1_s_q, s1_spec_q;
  logic [EXP_W-1:0] s1_e_q;
  logic [SW-1:0] s1_bm_q, s1_sm_q;
  logic [W-1:0] s1_sv_q;
  logic [3:0] s1_sf_q;
  logic [TAG_W-1:0] s1_tag_q;
  // stage 1: register the swapped operands with the small significand aligned into G/R/S
  always_ff @(posedge clock) begin
    if (reset) v1_q <= 1'b0;
    else if (ld1) v1_q <= in_valid;
    if (ld1) begin
      s1_sub_q <= sa ^ sb;
      s1_s_q <= swap ? sb : sa;
      s1_e_q <= swap ? xb : xa;
      s1_bm_q <= {swap ? mb : ma, 3'b000};
      s1_sm_q <= {sh[2*SW-1:SW+1], |sh[SW:0]};
      s1_spec_q <= spec_d;
      s1_sv_q <= sv_d;
      s1_sf_q <= sf_d;
      s1_tag_q <= in_tag;
    end
  end
  logic [N-1:0] sum_d;
  logic [LW-1:0] lz_d;
  // stage 2 logic: magnitude add/subtract (never negative) and leading-zero count incl. carry bit
  always_comb begin
    sum_d = s1_sub_q ? {1'b0, s1_bm_q} - {1'b0, s1_sm_q} : {1'b0, s1_bm_q} + {1'b0, s1_sm_q};
    lz_d = LW'(N);
    for (int i = 0; i < N; i++) if (sum_d[i]) lz_d = LW'(N - 1 - i);
  end
  logic s2_s_q, s2_spec_q;
  logic [EXP_W-1:0] s2_e_q;
  logic [N-1:0] s2_sum_q;
  logic [LW-1:0] s2_lz_q;
  logic [W-1:0] s2_sv_q;
  logic [3:0] s2_sf_q;
  logic [TAG_W-1:0] s2_tag_q;
  // stage 2: register raw sum and its leading-zero count
  always_ff @(posedge clock) begin
    if (reset) v2_q <= 1'b0;
    else if (ld2) v2_q <= v1_q;
    if (ld2) begin
      s2_s_q <= s1_s_q;
      s2_e_q <= s1_e_q;
      s2_sum_q <= sum_d;
      s2_lz_q <= lz_d;
      s2_spec_q <= s1_spec_q;
      s2_sv_q <= s1_sv_q;
      s2_sf_q <= s1_sf_q;
      s2_tag_q <= s1_tag_q;
    end
  end
  logic [EXP_W:0] ls, ef, er;
  logic [SW-1:0] nm;
  logic [MAN_W+1:0] rnd;
  logic inc, inx, ovf;
  logic [W-1:0] res_d;
  logic [3:0] flg_d;
  // stage 3 logic: normalise (left shift capped so tiny results go subnormal), round to nearest even
  always_comb begin
    ls = (32'(s2_lz_q) < 32'(s2_e_q)) ? (EXP_W+1)'(s2_lz_q - 1'b1) : {1'b0, s2_e_q - 1'b1};
    nm = s2_sum_q[N-1] ? {s2_sum_q[N-1:2], |s2_sum_q[1:0]} : s2_sum_q[N-2:0] << ls;
    ef = s2_sum_q[N-1] ? {1'b0, s2_e_q} + 1'b1 : nm[SW-1] ? {1'b0, s2_e_q} - ls : '0;
    inc = nm[2] & (nm[1] | nm[0] | nm[3]);
    inx = |nm[2:0];
    rnd = {1'b0, nm[SW-1:3]} + {{(MAN_W+1){1'b0}}, inc};
    er = rnd[MAN_W+1] ? ef + 1'b1 : (ef == '0 && rnd[MAN_W]) ? {{EXP_W{1'b0}}, 1'b1} : ef;
    ovf = er >= {1'b0, EMAX};
    res_d = s2_spec_q ? s2_sv_q : (s2_sum_q == '0) ? '0 : ovf ? {s2_s_q, EMAX, {MAN_W{1'b0}}} : {s2_s_q, er[EXP_W-1:0], rnd[MAN_W-1:0]};
    flg_d = s2_spec_q ? s2_sf_q : (s2_sum_q == '0) ? 4'b0000 : ovf ? 4'b0101 : {2'b00, ef == '0 && inx, inx};
  end
  logic [W-1:0] sum_q;
  logic [TAG_W-1:0] tag_q;
  logic [3:0] flg_q;
  // stage 3: output register, only overwritten by a real operation so outputs hold under stall
  always_ff @(posedge clock) begin
    if (reset) begin
      v3_q <= 1'b0;
      sum_q <= '0;
      tag_q <= '0;
      flg_q <= '0;
    end else if (ld3) begin
      v3_q <= v2_q;
      if (v2_q) begin
        sum_q <= res_d;
        tag_q <= s2_tag_q;
        flg_q <= flg_d;
      end
    end
  end
  assign out_sum = sum_q;
  assign out_tag = tag_q;
  assign out_flags = flg_q;
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed and randomized checks of fp_add_pipe against an exact-arithmetic binary16 model
module tb_fp_add_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, in_sub, out_valid, out_ready;
  logic [15:0] in_opA, in_opB, out_sum;
  logic [7:0] in_tag, out_tag;
  logic [3:0] out_flags;
  int checks = 0;
  int failures = 0;
  typedef struct packed {logic [15:0] s; logic [3:0] f; logic [7:0] t;} exp_t;
  exp_t sb_q[$];
  logic hold_v;
  logic [27:0] hold;
  always #5 clk = ~clk;
  fp_add_pipe dut (
    .clock(clk), .reset(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_opA(in_opA), .in_opB(in_opB), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_tag(out_tag), .out_flags(out_flags)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  // exact value model: operands as integers in units of 2^-24, then round the exact sum
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic sub);
    logic sa, sb;
    logic [4:0] ea, eb;
    logic [9:0] fa, fb;
    longint va, vb, x, m, qq, rem, half;
    int p, sh, e;
    sa = a[15]; sb = b[15] ^ sub;
    ea = a[14:10]; eb = b[14:10]; fa = a[9:0]; fb = b[9:0];
    if ((ea == 31 && fa != 0) || (eb == 31 && fb != 0))
      return {(ea == 31 && fa != 0 && !fa[9]) || (eb == 31 && fb != 0 && !fb[9]), 3'b000, 16'h7E00};
    if (ea == 31 && eb == 31) return (sa != sb) ? {4'b1000, 16'h7E00} : {4'b0000, sa, 15'h7C00};
    if (ea == 31) return {4'b0000, sa, 15'h7C00};
    if (eb == 31) return {4'b0000, sb, 15'h7C00};
    if (a[14:0] == 0 && b[14:0] == 0) return {4'b0000, sa & sb, 15'h0000};
    if (b[14:0] == 0) return {4'b0000, a};
    if (a[14:0] == 0) return {4'b0000, sb, b[14:0]};
    va = longint'({ea != 0, fa}) << ((ea == 0) ? 0 : ea - 1);
    vb = longint'({eb != 0, fb}) << ((eb == 0) ? 0 : eb - 1);
    x = (sa ? -va : va) + (sb ? -vb : vb);
    if (x == 0) return 20'h00000;
    m = (x < 0) ? -x : x;
    p = 0;
    while ((m >> (p + 1)) != 0) p++;
    if (p < 10) return {4'b0000, x < 0, 5'd0, m[9:0]};
    sh = p - 10;
    qq = m >> sh;
    rem = m - (qq << sh);
    half = (sh > 0) ? (longint'(1) << (sh - 1)) : 0;
    if (sh > 0 && (rem > half || (rem == half && qq[0]))) qq++;
    e = p - 9;
    if (qq == 2048) begin qq = 1024; e++; end
    if (e >= 31) return {4'b0101, x < 0, 15'h7C00};
    return {3'b000, rem != 0, x < 0, 5'(e), qq[9:0]};
  endfunction
  function automatic logic [15:0] rnd_b(input logic [15:0] a);
    logic [15:0] r;
    r = 16'($urandom);
    case ($urandom_range(0, 3))
      0: return r;
      1: return {r[15], a[14:10], r[9:0]};
      2: return {r[15], a[14:10] + 5'd1, r[9:0]};
      default: return {r[15], 3'b000, r[11:0]};
    endcase
  endfunction
  // one clock of streaming: drive at negedge, score outputs and record accepts
  task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b, input logic sub,
                      input logic [7:0] tag, input logic ordy);
    exp_t e;
    logic [19:0] m;
    @(negedge clk);
    in_valid = iv; in_opA = a; in_opB = b; in_sub = sub; in_tag = tag; out_ready = ordy;
    #1;
    if (out_valid && out_ready) begin
      chk("queue_nonempty", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("sum", out_sum, e.s);
        chk("flags", out_flags, e.f);
        chk("tag", out_tag, e.t);
      end
    end
    if (out_valid && !out_ready) begin
      if (hold_v) chk("stable", {out_sum, out_flags, out_tag}, hold);
      hold_v = 1'b1;
      hold = {out_sum, out_flags, out_tag};
    end else hold_v = 1'b0;
    if (in_valid && in_ready) begin
      m = model(a, b, sub);
      sb_q.push_back({m[15:0], m[19:16], tag});
    end
  endtask
  // single isolated operation with latency measurement and constant expectations
  task automatic op1(input string nm, input logic [15:0] a, input logic [15:0] b, input logic sub,
                     input logic [7:0] tag, input logic [15:0] es, input logic [3:0] ef);
    int lat;
    hold_v = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_opA = a; in_opB = b; in_sub = sub; in_tag = tag; out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_sum"}, out_sum, es);
    chk({nm, "_flags"}, out_flags, ef);
    chk({nm, "_tag"}, out_tag, tag);
  endtask
  initial begin
    logic [15:0] a;
    logic [15:0] bpa [5];
    logic [15:0] bpb [5];
    int sent;
    rst = 1'b1; in_valid = 1'b0; in_sub = 1'b0; in_opA = '0; in_opB = '0; in_tag = '0; out_ready = 1'b0;
    hold_v = 1'b0; hold = '0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_out_flags", out_flags, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    op1("one_plus_one", 16'h3C00, 16'h3C00, 1'b0, 8'h5A, 16'h4000, 4'h0);
    op1("x_minus_x", 16'h3C00, 16'h3C00, 1'b1, 8'h01, 16'h0000, 4'h0);
    op1("negz_plus_negz", 16'h8000, 16'h8000, 1'b0, 8'h02, 16'h8000, 4'h0);
    op1("rne_tie_even", 16'h3C00, 16'h1000, 1'b0, 8'h03, 16'h3C00, 4'h1);
    op1("rne_tie_up", 16'h3C01, 16'h1000, 1'b0, 8'h04, 16'h3C02, 4'h1);
    op1("overflow", 16'h7BFF, 16'h7BFF, 1'b0, 8'h05, 16'h7C00, 4'h5);
    op1("sub_plus_sub", 16'h0001, 16'h0001, 1'b0, 8'h06, 16'h0002, 4'h0);
    op1("norm_to_sub", 16'h0400, 16'h0001, 1'b1, 8'h07, 16'h03FF, 4'h0);
    op1("inf_minus_inf", 16'h7C00, 16'hFC00, 1'b0, 8'h08, 16'h7E00, 4'h8);
    op1("snan", 16'h7D00, 16'h3C00, 1'b0, 8'h09, 16'h7E00, 4'h8);
    op1("qnan", 16'h7E00, 16'h3C00, 1'b0, 8'h0A, 16'h7E00, 4'h0);
    op1("inf_plus_x", 16'h7C00, 16'h3C00, 1'b0, 8'h0B, 16'h7C00, 4'h0);
    op1("x_plus_zero", 16'h3555, 16'h0000, 1'b0, 8'h0C, 16'h3555, 4'h0);
    op1("cancel_norm", 16'h3C01, 16'h3C00, 1'b1, 8'h0D, 16'h1400, 4'h0);
    for (int i = 0; i < 5; i++) begin
      bpa[i] = 16'($urandom);
      bpb[i] = rnd_b(bpa[i]);
    end
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b1, bpa[sent], bpb[sent], 1'b0, 8'(8'h40 + sent), 1'b0);
      if (in_valid && in_ready) sent++;
    end
    chk("bp_accepts", sent, 3);
    chk("bp_in_ready_low", in_ready, 0);
    for (int c = 0; c < 30 && (sent < 5 || sb_q.size() > 0); c++) begin
      step(sent < 5, bpa[sent < 5 ? sent : 0], bpb[sent < 5 ? sent : 0], 1'b0, 8'(8'h40 + sent), 1'b1);
      if (in_valid && in_ready) sent++;
    end
    chk("bp_all_sent", sent, 5);
    chk("bp_all_out", sb_q.size(), 0);
    step(1'b1, 16'h3C00, 16'h3C00, 1'b0, 8'h21, 1'b0);
    step(1'b1, 16'h4000, 16'h3C00, 1'b0, 8'h22, 1'b0);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_out_sum", out_sum, 0);
    rst = 1'b0;
    sb_q.delete();
    hold_v = 1'b0;
    for (int c = 0; c < 6; c++) step(1'b0, 16'h0, 16'h0, 1'b0, 8'h0, 1'b1);
    op1("post_reset", 16'h4000, 16'h4000, 1'b0, 8'h33, 16'h4400, 4'h0);
    for (int c = 0; c < 400; c++) begin
      a = 16'($urandom);
      step($urandom_range(0, 3) != 0, a, rnd_b(a), 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) != 0);
    end
    for (int c = 0; c < 20 && sb_q.size() > 0; c++) step(1'b0, 16'h0, 16'h0, 1'b0, 8'h0, 1'b1);
    chk("random_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
